xi_graph_mem_arbiter: RTL
=========================

Name: xi_graph_mem_arbiter

Overview:
Single-port arbiter that shares the 160-bit graph BRAM between the host DMA loader (64-bit lane writes) and the multi-core engine's external read and write ports. It grants one access per cycle with fixed priority and promotes DMA when it has been starved too long. Read data returns with fixed latency and tagged valid. It sits between the AXI-Full DMA front end, xi_multicore_top ext_* ports and the graph_mem array.

Parameters:
ADDR_W, 16, graph node address width
STARVE_LIM, 8, consecutive stalled DMA cycles before DMA is promoted to top priority (legal range 1..255)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
dma_valid  in  1  DMA lane-write request
dma_ready  out  1  DMA request accepted this cycle
dma_addr  in  ADDR_W  target node
dma_lane  in  2  64-bit lane within node (0,1,2; 3 illegal)
dma_data  in  64  lane data
eng_rd_valid  in  1  engine read request
eng_rd_ready  out  1  engine read accepted
eng_rd_addr  in  ADDR_W  read node
eng_rsp_valid  out  1  read data valid
eng_rsp_data  out  160  read data
eng_wr_valid  in  1  engine write request
eng_wr_ready  out  1  engine write accepted
eng_wr_addr  in  ADDR_W  write node
eng_wr_data  in  160  full-node write data
mem_en  out  1  BRAM enable
mem_we  out  1  BRAM write
mem_addr  out  ADDR_W  BRAM address
mem_wmask  out  3  per-lane write enable (bit0=[63:0], bit1=[127:64], bit2=[159:128])
mem_wdata  out  160  BRAM write data
mem_rdata  in  160  BRAM read data, 1-cycle latency
stat_clear  in  1  synchronous clear of counters and error flag
stat_conflicts  out  32  cycles with >=2 requesters valid
stat_promotions  out  32  DMA grants issued via starvation promotion
dma_lane_err  out  1  sticky: a lane-3 DMA request was accepted

Behaviour:
- Reset (async, rst_n low): all readies 0, mem_en/mem_we/mem_wmask 0, eng_rsp_valid 0, counters 0, dma_lane_err 0, starvation counter 0.
- Grants are combinational from current valids and registered state. Handshake = valid && ready, same cycle. Ready is never asserted without the matching valid. At most one ready is high per cycle.
- Normal priority: eng_wr > eng_rd > dma.
- Starvation: wait_cnt (8-bit) increments each cycle dma_valid=1 and dma_ready=0, saturating at STARVE_LIM. It clears on a DMA handshake and holds when dma_valid=0. When wait_cnt==STARVE_LIM and dma_valid=1, DMA has top priority, and stat_promotions increments on that grant.
- Engine write grant: mem_en=1, mem_we=1, mem_wmask=3'b111, mem_wdata=eng_wr_data.
- Engine read grant: mem_en=1, mem_we=0, mem_wmask=0. Next cycle eng_rsp_valid=1 and eng_rsp_data=mem_rdata, combinational from the BRAM output register. Latency is exactly 1 cycle. There is no backpressure on responses.
- DMA grant, lanes 0..2: mem_we=1, mem_wmask=one-hot(lane), dma_data replicated into lanes 0 and 1. Lane 2 uses dma_data[31:0], and dma_data[63:32] is ignored.
- DMA grant, lane 3: handshake completes, mem_en=0, dma_lane_err set. The request still counts as a DMA grant for wait_cnt.
- No grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Same-address engine read and write valid together: the write wins this cycle. The read waits and returns the new data.
- stat_conflicts increments each cycle at least two of {dma_valid, eng_rd_valid, eng_wr_valid} are 1.
- Both counters saturate at 32'hFFFF_FFFF. stat_clear zeroes both counters and dma_lane_err next edge, and clear wins over a same-cycle increment.
- Reset mid-operation: a pending eng_rsp_valid is dropped (0 immediately). Requesters must re-issue.

Test Plan:
- Reset, then eng_rd_valid addr 0x0010 with BRAM holding 0xA5.. -> eng_rd_ready same cycle, eng_rsp_valid next cycle with data 0xA5..; no further valids.
- DMA lanes 0,1,2 to addr 0x0003 with data 0x1111..,0x2222..,0x3333_3333 -> mem_wmask 001,010,100; read back = {32'h3333_3333, 64'h2222.., 64'h1111..}.
- eng_wr and eng_rd both valid to addr 0x0020 -> write granted first, read next cycle returns the written value; stat_conflicts=1.
- STARVE_LIM=4, dma_valid and eng_rd_valid held high continuously -> DMA granted on the 5th cycle; stat_promotions=1; wait_cnt back to 0; the engine read is granted the following cycle.
- DMA lane 3 request -> dma_ready=1, mem_en=0, dma_lane_err=1; then stat_clear -> dma_lane_err=0 and counters=0.
- Assert rst_n low in the cycle after an engine read grant -> eng_rsp_valid=0 immediately, all readies 0; after release, a fresh read completes normally.

Source files
------------

// File: rtl/xi_graph_mem_arbiter_if.sv
// xi_graph_mem_arbiter_if
// Bundles the request/response handshakes of the graph BRAM arbiter and the
// BRAM-side bus.
//   slave  : the arbiter. It receives DMA and engine requests, returns the read
//            response and drives the BRAM port.
//   master : the requesters plus the BRAM. They drive requests and mem_rdata,
//            and observe the readies, the response and the BRAM controls.
// Signals:
//   dma_valid/ready/addr/lane/data       DMA 64-bit lane writes
//   eng_rd_valid/ready/addr              engine reads
//   eng_rsp_valid/data                   engine read response (1-cycle latency)
//   eng_wr_valid/ready/addr/data         engine full-node writes
//   mem_en/we/addr/wmask/wdata/rdata     160-bit single-port BRAM
interface xi_graph_mem_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic              dma_valid;
    logic              dma_ready;
    logic [ADDR_W-1:0] dma_addr;
    logic [1:0]        dma_lane;
    logic [63:0]       dma_data;

    logic              eng_rd_valid;
    logic              eng_rd_ready;
    logic [ADDR_W-1:0] eng_rd_addr;
    logic              eng_rsp_valid;
    logic [159:0]      eng_rsp_data;

    logic              eng_wr_valid;
    logic              eng_wr_ready;
    logic [ADDR_W-1:0] eng_wr_addr;
    logic [159:0]      eng_wr_data;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [2:0]        mem_wmask;
    logic [159:0]      mem_wdata;
    logic [159:0]      mem_rdata;

    modport slave (
        input  dma_valid, dma_addr, dma_lane, dma_data,
        output dma_ready,
        input  eng_rd_valid, eng_rd_addr,
        output eng_rd_ready, eng_rsp_valid, eng_rsp_data,
        input  eng_wr_valid, eng_wr_addr, eng_wr_data,
        output eng_wr_ready,
        output mem_en, mem_we, mem_addr, mem_wmask, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output dma_valid, dma_addr, dma_lane, dma_data,
        input  dma_ready,
        output eng_rd_valid, eng_rd_addr,
        input  eng_rd_ready, eng_rsp_valid, eng_rsp_data,
        output eng_wr_valid, eng_wr_addr, eng_wr_data,
        input  eng_wr_ready,
        input  mem_en, mem_we, mem_addr, mem_wmask, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/xi_graph_mem_arbiter.sv
// xi_graph_mem_arbiter
// Shares one 160-bit graph BRAM port between the DMA loader (64-bit lane
// writes) and the engine's read and write ports. The arbiter grants one access
// per cycle. Fixed priority is eng_wr > eng_rd > dma. DMA is promoted to the
// top once it has been stalled STARVE_LIM consecutive cycles.
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   bus (slave)       request/response handshakes and the BRAM port
//   stat_clear        synchronous clear of the counters and dma_lane_err
//   stat_conflicts    cycles where two or more requesters were valid (saturating)
//   stat_promotions   DMA grants won through starvation promotion (saturating)
//   dma_lane_err      sticky flag: a lane-3 DMA request was accepted
module xi_graph_mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int STARVE_LIM = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    xi_graph_mem_arbiter_if.slave     bus,
    input  logic                      stat_clear,
    output logic [31:0]               stat_conflicts,
    output logic [31:0]               stat_promotions,
    output logic                      dma_lane_err
);
    localparam logic [7:0] LIM = 8'(STARVE_LIM);

    typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD, GNT_DMA} gnt_e;

    gnt_e              gnt;
    logic [7:0]        wait_cnt;
    logic              rd_pend;
    logic              promote;
    logic              conflict;
    logic              dma_lane_ok;
    logic [ADDR_W-1:0] addr_sel;

    assign promote     = bus.dma_valid && (wait_cnt == LIM);
    assign conflict    = (bus.dma_valid && bus.eng_rd_valid) ||
                         (bus.dma_valid && bus.eng_wr_valid) ||
                         (bus.eng_rd_valid && bus.eng_wr_valid);
    assign dma_lane_ok = (bus.dma_lane != 2'd3);

    // The grant is gated by rst_n so that no ready escapes while reset is held.
    always_comb begin
        gnt = GNT_NONE;
        if (!rst_n)                gnt = GNT_NONE;
        else if (promote)          gnt = GNT_DMA;
        else if (bus.eng_wr_valid) gnt = GNT_WR;
        else if (bus.eng_rd_valid) gnt = GNT_RD;
        else if (bus.dma_valid)    gnt = GNT_DMA;
    end

    always_comb begin
        bus.dma_ready    = 1'b0;
        bus.eng_rd_ready = 1'b0;
        bus.eng_wr_ready = 1'b0;
        bus.mem_en       = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_wmask    = 3'b000;
        bus.mem_wdata    = '0;
        addr_sel         = '0;
        case (gnt)
            GNT_WR: begin
                bus.eng_wr_ready = 1'b1;
                bus.mem_en       = 1'b1;
                bus.mem_we       = 1'b1;
                bus.mem_wmask    = 3'b111;
                bus.mem_wdata    = bus.eng_wr_data;
                addr_sel         = bus.eng_wr_addr;
            end
            GNT_RD: begin
                bus.eng_rd_ready = 1'b1;
                bus.mem_en       = 1'b1;
                addr_sel         = bus.eng_rd_addr;
            end
            GNT_DMA: begin
                // A lane-3 request is accepted so the loader never hangs, but it
                // never reaches the BRAM.
                bus.dma_ready = 1'b1;
                if (dma_lane_ok) begin
                    bus.mem_en    = 1'b1;
                    bus.mem_we    = 1'b1;
                    bus.mem_wmask = 3'(3'b001 << bus.dma_lane);
                    // Lane 2 is only 32 bits wide, so it takes dma_data[31:0].
                    bus.mem_wdata = {bus.dma_data[31:0], bus.dma_data, bus.dma_data};
                    addr_sel      = bus.dma_addr;
                end
            end
            default: ;
        endcase
    end

    assign bus.mem_addr      = addr_sel;
    assign bus.eng_rsp_valid = rd_pend;
    assign bus.eng_rsp_data  = bus.mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt        <= 8'd0;
            rd_pend         <= 1'b0;
            stat_conflicts  <= 32'd0;
            stat_promotions <= 32'd0;
            dma_lane_err    <= 1'b0;
        end else begin
            rd_pend <= (gnt == GNT_RD);

            if (gnt == GNT_DMA)
                wait_cnt <= 8'd0;
            else if (bus.dma_valid && wait_cnt < LIM)
                wait_cnt <= wait_cnt + 8'd1;

            if (stat_clear) begin
                stat_conflicts  <= 32'd0;
                stat_promotions <= 32'd0;
                dma_lane_err    <= 1'b0;
            end else begin
                if (conflict && stat_conflicts != 32'hFFFF_FFFF)
                    stat_conflicts <= stat_conflicts + 32'd1;
                if (gnt == GNT_DMA && promote && stat_promotions != 32'hFFFF_FFFF)
                    stat_promotions <= stat_promotions + 32'd1;
                if (gnt == GNT_DMA && !dma_lane_ok)
                    dma_lane_err <= 1'b1;
            end
        end
    end
endmodule
